// File: rtl/pipeline_one.sv
// Five-port ingress buffer: per-port DEPTH-entry FIFOs sharing one data word,
// popped together into registered outputs. Define PIPELINE_ONE_PARITY_EN to compile in the even-parity bit.
module pipeline_one #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] inc,
  input  logic       nsig,
  input  logic       ssig,
  input  logic       esig,
  input  logic       wsig,
  input  logic       lsig,
  input  logic       clksig,
  output logic [9:0] noun,
  output logic [9:0] soun,
  output logic [9:0] eoun,
  output logic [9:0] woun,
  output logic [9:0] loun
);

  localparam int NP = 5;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [6:0]    mem_q    [NP][DEPTH];
  logic [6:0]    mem_d    [NP][DEPTH];
  logic [AW-1:0] wr_ptr_q [NP];
  logic [AW-1:0] wr_ptr_d [NP];
  logic [AW-1:0] rd_ptr_q [NP];
  logic [AW-1:0] rd_ptr_d [NP];
  logic [CW-1:0] count_q  [NP];
  logic [CW-1:0] count_d  [NP];
  logic          ovf_q    [NP];
  logic          ovf_d    [NP];
  logic [9:0]    out_q    [NP];
  logic [9:0]    out_d    [NP];

  logic [NP-1:0] push;
  logic [NP-1:0] do_push;
  logic [NP-1:0] do_pop;
  logic [6:0]    head [NP];
  logic          par  [NP];

  // Port order in every array: 0=north, 1=south, 2=east, 3=west, 4=local.
  assign push = {lsig, wsig, esig, ssig, nsig};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    out_d    = out_q;
    do_push  = '0;
    do_pop   = '0;
    for (int p = 0; p < NP; p++) begin
      head[p] = mem_q[p][rd_ptr_q[p]];
`ifdef PIPELINE_ONE_PARITY_EN
      par[p] = ^head[p];
`else
      par[p] = 1'b0;
`endif
      do_pop[p]  = clksig && (count_q[p] != '0);
      // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
      do_push[p] = push[p] && ((count_q[p] != FULL_CNT) || do_pop[p]);

      if (clksig) begin
        ovf_d[p] = 1'b0;
        out_d[p] = do_pop[p] ? {1'b1, par[p], ovf_q[p], head[p]} : 10'b0;
      end
      if (push[p] && !do_push[p]) begin
        ovf_d[p] = 1'b1;
      end
      if (do_push[p]) begin
        mem_d[p][wr_ptr_q[p]] = inc;
        wr_ptr_d[p]           = wr_ptr_q[p] + PTR_ONE;
      end
      if (do_pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + PTR_ONE;
      end
      case ({do_push[p], do_pop[p]})
        2'b10:   count_d[p] = count_q[p] + CNT_ONE;
        2'b01:   count_d[p] = count_q[p] - CNT_ONE;
        default: count_d[p] = count_q[p];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[p][i] <= '0;
        end
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        ovf_q[p]    <= 1'b0;
        out_q[p]    <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
    end
  end

  assign noun = out_q[0];
  assign soun = out_q[1];
  assign eoun = out_q[2];
  assign woun = out_q[3];
  assign loun = out_q[4];

endmodule

// File: tb/tb_pipeline_one.sv
// Self-checking bench for pipeline_one: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pipeline_one;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] inc;
  logic       nsig, ssig, esig, wsig, lsig, clksig;
  logic [9:0] noun, soun, eoun, woun, loun;

  always #5 clk = ~clk;

  pipeline_one #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inc(inc),
    .nsig(nsig), .ssig(ssig), .esig(esig), .wsig(wsig), .lsig(lsig),
    .clksig(clksig),
    .noun(noun), .soun(soun), .eoun(eoun), .woun(woun), .loun(loun)
  );

  logic [9:0] obs [5];
  assign obs[0] = noun;
  assign obs[1] = soun;
  assign obs[2] = eoun;
  assign obs[3] = woun;
  assign obs[4] = loun;

  // Reference model: one queue per port, a sticky overflow bit, and expected outputs.
  logic [6:0] mq   [5][$];
  logic       mov  [5];
  logic [9:0] mexp [5];

  int checks = 0;
  int errors = 0;
  string names [5] = '{"north", "south", "east", "west", "local"};

  function automatic logic ref_parity(input logic [6:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) if (d[i]) ones++;
`ifdef PIPELINE_ONE_PARITY_EN
    return (ones % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 5; p++) begin
      mq[p].delete();
      mov[p]  = 1'b0;
      mexp[p] = 10'b0;
    end
  endtask

  // Drive one clock's worth of inputs, then advance the model by that edge.
  task automatic cycle(input logic [4:0] pushv, input logic adv, input logic [6:0] data);
    logic [6:0] h;
    {lsig, wsig, esig, ssig, nsig} = pushv;
    clksig = adv;
    inc    = data;
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      if (adv) begin
        if (mq[p].size() > 0) begin
          h = mq[p].pop_front();
          mexp[p] = {1'b1, ref_parity(h), mov[p], h};
        end else begin
          mexp[p] = 10'b0;
        end
        mov[p] = 1'b0;
      end
      if (pushv[p]) begin
        if (mq[p].size() < DEPTH) mq[p].push_back(data);
        else mov[p] = 1'b1;
      end
    end
    {lsig, wsig, esig, ssig, nsig} = 5'b0;
    clksig = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== 10'b0) begin
        errors++;
        $display("[TB] FAIL rst_async_%s actual=%h required=%h", names[p], obs[p], 10'b0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {lsig, wsig, esig, ssig, nsig} = 5'b11111;
    clksig = 1'b1;
    inc    = 7'h55;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== 10'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold_%s actual=%h required=%h", names[p], obs[p], 10'b0);
      end
    end
    {lsig, wsig, esig, ssig, nsig} = 5'b0;
    clksig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(5'b00000, 1'b1, 7'h00);
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== 10'b0) begin
        errors++;
        $display("[TB] FAIL reset_empty_%s actual=%h required=%h", names[p], obs[p], 10'b0);
      end
    end
  endtask

  task automatic test_single_north();
    cycle(5'b00001, 1'b0, 7'b0000101);
    cycle(5'b00000, 1'b1, 7'h00);
    checks++;
    if (noun !== 10'b1000000101) begin
      errors++;
      $display("[TB] FAIL north_single actual=%b required=%b", noun, 10'b1000000101);
    end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== mexp[p]) begin
        errors++;
        $display("[TB] FAIL north_model_%s actual=%h required=%h", names[p], obs[p], mexp[p]);
      end
    end
    // Outputs must hold while the advance strobe is low.
    cycle(5'b00000, 1'b0, 7'h7F);
    checks++;
    if (noun !== 10'b1000000101) begin
      errors++;
      $display("[TB] FAIL north_hold actual=%b required=%b", noun, 10'b1000000101);
    end
  endtask

  task automatic test_east_parity();
    logic [9:0] want;
`ifdef PIPELINE_ONE_PARITY_EN
    want = 10'b1101100001;
`else
    want = 10'b1001100001;
`endif
    cycle(5'b00100, 1'b0, 7'b1100001);
    cycle(5'b00000, 1'b1, 7'h00);
    checks++;
    if (eoun !== want) begin
      errors++;
      $display("[TB] FAIL east_parity actual=%b required=%b", eoun, want);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] words [5];
    logic [9:0] got;
    words = '{7'h27, 7'h2C, 7'h08, 7'h01, 7'h17};
    for (int i = 0; i < 5; i++) cycle(5'b10000, 1'b0, words[i]);
    for (int i = 0; i < 5; i++) begin
      cycle(5'b00000, 1'b1, 7'h00);
      got = loun;
      checks++;
      if (i < 4) begin
        if (got[9] !== 1'b1 || got[7] !== (i == 0) || got[6:0] !== words[i]) begin
          errors++;
          $display("[TB] FAIL overflow_pop%0d actual=%h required data=%h ovf=%0d valid=1",
                   i, got, words[i], (i == 0));
        end
      end else if (got !== 10'b0) begin
        errors++;
        $display("[TB] FAIL overflow_empty actual=%h required=%h", got, 10'b0);
      end
      checks++;
      if (got !== mexp[4]) begin
        errors++;
        $display("[TB] FAIL overflow_model%0d actual=%h required=%h", i, got, mexp[4]);
      end
    end
  endtask

  task automatic test_broadcast();
    cycle(5'b11111, 1'b0, 7'h24);
    cycle(5'b00000, 1'b1, 7'h00);
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== 10'h224) begin
        errors++;
        $display("[TB] FAIL broadcast_%s actual=%h required=%h", names[p], obs[p], 10'h224);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [6:0] words [4];
    logic [9:0] want;
    words = '{7'h11, 7'h22, 7'h33, 7'h44};
    for (int i = 0; i < 4; i++) cycle(5'b01000, 1'b0, words[i]);
    cycle(5'b01000, 1'b1, 7'h5A);
    want = {1'b1, ref_parity(7'h11), 1'b0, 7'h11};
    checks++;
    if (woun !== want) begin
      errors++;
      $display("[TB] FAIL full_pushpop actual=%h required=%h", woun, want);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(5'b00000, 1'b1, 7'h00);
      want = (i < 3) ? {1'b1, ref_parity(words[i+1]), 1'b0, words[i+1]}
                     : {1'b1, ref_parity(7'h5A), 1'b0, 7'h5A};
      checks++;
      if (woun !== want) begin
        errors++;
        $display("[TB] FAIL full_drain%0d actual=%h required=%h", i, woun, want);
      end
    end
    // Empty FIFO: the pop sees empty while the push is stored.
    cycle(5'b01000, 1'b1, 7'h3C);
    checks++;
    if (woun !== 10'b0) begin
      errors++;
      $display("[TB] FAIL empty_pushpop actual=%h required=%h", woun, 10'b0);
    end
    cycle(5'b00000, 1'b1, 7'h00);
    want = {1'b1, ref_parity(7'h3C), 1'b0, 7'h3C};
    checks++;
    if (woun !== want) begin
      errors++;
      $display("[TB] FAIL empty_pushpop_kept actual=%h required=%h", woun, want);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) cycle(5'b11111, 1'b0, 7'(7'h40 + i));
    cycle(5'b00000, 1'b1, 7'h00);
    pulse_reset();
    cycle(5'b00000, 1'b1, 7'h00);
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs[p] !== 10'b0 || obs[p] !== mexp[p]) begin
        errors++;
        $display("[TB] FAIL midreset_empty_%s actual=%h required=%h", names[p], obs[p], 10'b0);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] pv;
    logic       adv;
    for (int c = 0; c < 400; c++) begin
      pv  = 5'($urandom);
      adv = ($urandom_range(0, 9) < 4);
      cycle(pv, adv, 7'($urandom));
      for (int p = 0; p < 5; p++) begin
        checks++;
        if (obs[p] !== mexp[p]) begin
          errors++;
          $display("[TB] FAIL random_c%0d_%s actual=%h required=%h", c, names[p], obs[p], mexp[p]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inc = '0;
    {lsig, wsig, esig, ssig, nsig} = 5'b0;
    clksig = 1'b0;
    test_reset();
    test_single_north();
    test_east_parity();
    test_overflow();
    test_broadcast();
    test_full_push_pop();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_one.md
PIPELINE_ONE -- requirements
Module: pipeline_one

Interface
REQ-001 Parameter DEPTH, default 4, is the per-port FIFO depth in entries (power of two, 2..16).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inc  input  7  shared ingress data word for all five ports.
REQ-005 nsig  input  1  north write strobe; pushes inc into the north FIFO.
REQ-006 ssig  input  1  south write strobe; pushes inc into the south FIFO.
REQ-007 esig  input  1  east write strobe; pushes inc into the east FIFO.
REQ-008 wsig  input  1  west write strobe; pushes inc into the west FIFO.
REQ-009 lsig  input  1  local write strobe; pushes inc into the local FIFO.
REQ-010 clksig  input  1  advance strobe; pops one entry per port into the output registers.
REQ-011 noun, soun, eoun, woun, loun  output  10 each  registered port outputs: bit9 valid, bit8 parity, bit7 overflow, bits6:0 data.

Function
REQ-012 Five independent DEPTH-entry FIFOs of 7-bit words SHALL exist, one per port (N, S, E, W, L).
REQ-013 On a clk edge with a port strobe high and that FIFO not full, inc SHALL be written at the tail.
- Several strobes may be high in one cycle; every selected FIFO SHALL capture the same inc.
REQ-014 A push to a full FIFO without a simultaneous pop SHALL be dropped and SHALL set that port's sticky overflow flag.
REQ-015 On a clk edge with clksig high, each non-empty FIFO SHALL pop its head into its output register with bit9=1 and bits6:0=head.
- Latency: the output SHALL be visible one clk after the edge that samples clksig.
REQ-016 On a clk edge with clksig high and an empty FIFO, that port's output SHALL become 10'b0.
REQ-017 When clksig is low, all outputs SHALL hold their values.
REQ-018 Push and pop on the same edge SHALL both take effect, including when the FIFO is full (no drop, no overflow) and when it is empty.
- Empty case: the pop sees empty, so the output becomes 0, and the pushed word is stored.
REQ-019 Bit7 SHALL carry the port's overflow flag at each pop or empty-advance, and the flag SHALL clear on that same edge.
REQ-020 Bit8 SHALL be the XOR of bits6:0 (even parity) when the parity feature is compiled in, else 0.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked as a 0..DEPTH count.

Reset
REQ-022 While rst is high, all FIFOs SHALL be empty, all overflow flags 0, and all five outputs 10'b0, regardless of clk.
REQ-023 Assertion of rst mid-operation SHALL discard all stored words immediately; the first clk edge after deassertion SHALL behave as from power-up.

Configuration
REQ-024 Macro PIPELINE_ONE_PARITY_EN: when defined, bit8 of each output SHALL be the even-parity bit of the output data; when undefined, the parity logic SHALL be absent and bit8 SHALL be constant 0.

Verification
REQ-025 Reset, nsig with inc=7'b0000101, then clksig -> noun=10'b1000000101, all other outputs 0.
REQ-026 esig with inc=7'b1100001, then clksig, PARITY_EN defined -> eoun=10'b1101100001; undefined -> 10'b1001100001.
REQ-027 Five lsig pushes (7'h27, 7'h2C, 7'h08, 7'h01, 7'h17), DEPTH=4, then five clksig -> loun data 27, 2C, 08, 01 with bit7=1 on the first pop only, then loun=0.
REQ-028 nsig, ssig, esig, wsig, lsig all high with inc=7'h24, then clksig -> all five outputs carry data 7'h24, valid=1, parity=0.
REQ-029 FIFO full, wsig and clksig on the same edge -> no overflow; the oldest word is output and the new word is retained; rst pulse mid-burst -> all outputs 0 immediately and FIFOs empty.
